alu_op_sequencer: RTL and testbench

- Initiator-side driver for the registered 32-bit ALU: holds a small program of operand/opcode entries and issues them to the ALU one at a time.
- Waits out the ALU's clocked latency, then captures each result and zero flag into a result buffer.
- Sits between a host/control block and ALU_SIN_BLOQ; replaces hand-driven stimulus with a clocked, self-timed operation stream.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_prog_ram.sv | 33 +++
 rtl/alu_op_sequencer.sv | 176 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared opcodes, FSM encoding and helpers for the ALU sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_NOP = 3'b111
  } alu_op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Requested op counts beyond the table depth run the whole table once.
  function automatic int clamp_ops(input int n, input int depth);
    return (n > depth) ? depth : n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_prog_ram.sv
`default_nettype none
// ============================================================================
// Module   : alu_prog_ram
// Brief    : Program table, one write port, asynchronous read, no reset.
// Revision : 1.0 - initial release
// ============================================================================
module alu_prog_ram
  import alu_pkg::*;
#(
  parameter int WIDTH  = 2 * DATA_W_DEF + 3,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Issues stored operand/opcode entries to a registered ALU and
//            captures each result and zero flag into a result buffer.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int         DATA_W  = DATA_W_DEF,
  parameter int         DEPTH   = 8,
  parameter int         ADDR_W  = 3,
  parameter int         ALU_LAT = 1,
  parameter logic [2:0] NOP_SEL = ALU_NOP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_b_start,
  input  logic [ADDR_W:0]   i_u4_num_ops,
  input  logic              i_b_prog_we,
  input  logic [ADDR_W-1:0] i_u3_prog_addr,
  input  logic [DATA_W-1:0] i_ul_prog_a,
  input  logic [DATA_W-1:0] i_ul_prog_b,
  input  logic [2:0]        i_u3_prog_sel,
  input  logic [ADDR_W-1:0] i_u3_rd_addr,
  output logic [DATA_W-1:0] o_ul_rd_r,
  output logic              o_b_rd_z,
  output logic [DATA_W-1:0] o_ul_a,
  output logic [DATA_W-1:0] o_ul_b,
  output logic [2:0]        o_u3_sel,
  input  logic [DATA_W-1:0] i_ul_r,
  input  logic              i_bi_zflag,
  output logic              o_b_busy,
  output logic              o_b_done,
  output logic [ADDR_W:0]   o_u4_zcount
);

  localparam int         ENTRY_W = 2 * DATA_W + 3;
  localparam int         NUM_W   = ADDR_W + 1;
  localparam logic [3:0] C_LAT   = 4'(ALU_LAT);

  if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_bad_lat
    $error("alu_op_sequencer: ALU_LAT must be in 1..15");
  end

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_k;
  logic [NUM_W-1:0]  r_num;
  logic [3:0]        r_cnt;
  logic [NUM_W-1:0]  r_zcount;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [2:0]        r_sel;
  logic [DATA_W-1:0] r_res [DEPTH];
  logic [DEPTH-1:0]  r_z;

  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_entry;
  logic [ADDR_W-1:0]  w_raddr;
  logic [DATA_W-1:0]  w_ent_a;
  logic [DATA_W-1:0]  w_ent_b;
  logic [2:0]         w_ent_sel;
  logic [NUM_W-1:0]   w_num;
  logic               w_prog_we;
  logic               w_capture;
  logic               w_last;

  // Table is frozen while a run is in flight.
  assign w_prog_we = i_b_prog_we && (r_state == ST_IDLE);
  assign w_wdata   = {i_ul_prog_a, i_ul_prog_b, i_u3_prog_sel};

  // Idle presents entry 0 for the launch; a run looks one entry ahead.
  assign w_raddr = (r_state == ST_RUN) ? r_k + 1'b1 : '0;

  alu_prog_ram #(
    .WIDTH  (ENTRY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_prog_ram (
    .clk   (clk),
    .we    (w_prog_we),
    .waddr (i_u3_prog_addr),
    .wdata (w_wdata),
    .raddr (w_raddr),
    .rdata (w_entry)
  );

  assign w_ent_a   = w_entry[ENTRY_W-1 -: DATA_W];
  assign w_ent_b   = w_entry[3 +: DATA_W];
  assign w_ent_sel = w_entry[2:0];

  assign w_num     = NUM_W'(clamp_ops(int'(i_u4_num_ops), DEPTH));
  assign w_capture = (r_state == ST_RUN) && (r_cnt == '0);
  assign w_last    = ({1'b0, r_k} == (r_num - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_k      <= '0;
      r_num    <= '0;
      r_cnt    <= '0;
      r_zcount <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sel    <= NOP_SEL;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_b_start) begin
            r_num    <= w_num;
            r_k      <= '0;
            r_zcount <= '0;
            if (w_num == '0) begin
              r_state <= ST_DONE;
            end else begin
              r_a     <= w_ent_a;
              r_b     <= w_ent_b;
              r_sel   <= w_ent_sel;
              r_cnt   <= C_LAT;
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_zcount <= r_zcount + {{ADDR_W{1'b0}}, i_bi_zflag};
            if (w_last) begin
              r_a     <= '0;
              r_b     <= '0;
              r_sel   <= NOP_SEL;
              r_state <= ST_DONE;
            end else begin
              r_a   <= w_ent_a;
              r_b   <= w_ent_b;
              r_sel <= w_ent_sel;
              r_cnt <= C_LAT;
              r_k   <= r_k + 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_res[i] <= '0;
      end
      r_z <= '0;
    end else if (w_capture) begin
      r_res[r_k] <= i_ul_r;
      r_z[r_k]   <= i_bi_zflag;
    end
  end

  assign o_ul_rd_r   = r_res[i_u3_rd_addr];
  assign o_b_rd_z    = r_z[i_u3_rd_addr];
  assign o_ul_a      = r_a;
  assign o_ul_b      = r_b;
  assign o_u3_sel    = r_sel;
  assign o_b_busy    = (r_state != ST_IDLE);
  assign o_b_done    = (r_state == ST_DONE);
  assign o_u4_zcount = r_zcount;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Randomised scoreboard bench for alu_op_sequencer with a bench ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  num_ops = '0;
  logic        prog_we = 1'b0;
  logic [2:0]  prog_addr = '0;
  logic [31:0] prog_a = '0;
  logic [31:0] prog_b = '0;
  logic [2:0]  prog_sel = '0;
  logic [2:0]  rd_addr = '0;
  logic [31:0] rd_r;
  logic        rd_z;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_sel;
  logic [31:0] alu_r;
  logic        alu_z;
  logic        busy;
  logic        done;
  logic [3:0]  zcount;

  alu_op_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_b_start      (start),
    .i_u4_num_ops   (num_ops),
    .i_b_prog_we    (prog_we),
    .i_u3_prog_addr (prog_addr),
    .i_ul_prog_a    (prog_a),
    .i_ul_prog_b    (prog_b),
    .i_u3_prog_sel  (prog_sel),
    .i_u3_rd_addr   (rd_addr),
    .o_ul_rd_r      (rd_r),
    .o_b_rd_z       (rd_z),
    .o_ul_a         (alu_a),
    .o_ul_b         (alu_b),
    .o_u3_sel       (alu_sel),
    .i_ul_r         (alu_r),
    .i_bi_zflag     (alu_z),
    .o_b_busy       (busy),
    .o_b_done       (done),
    .o_u4_zcount    (zcount)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] sel);
    case (sel)
      3'b000:  return a & b;
      3'b001:  return a | b;
      default: return 32'h0;
    endcase
  endfunction

  // Bench ALU: one registered stage.
  always @(posedge clk) begin
    alu_r <= alu_fn(alu_a, alu_b, alu_sel);
    alu_z <= (alu_fn(alu_a, alu_b, alu_sel) == 32'h0);
  end

  typedef struct {
    int          done_cyc;
    int          zc;
    logic [31:0] res [8];
    logic        z   [8];
  } run_rec_t;

  run_rec_t    exp_q[$];
  logic [31:0] m_a [8];
  logic [31:0] m_b [8];
  logic [2:0]  m_sel [8];
  logic [31:0] m_res [8];
  logic        m_z [8];
  int          m_zc = 0;

  int checks = 0;
  int errors = 0;
  int runs_seen = 0;
  bit chk_req = 0;
  bit rst_req = 0;
  bit timeout_req = 0;
  bit fin_req = 0;

  // ---------------------------------------------------------------- monitor
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic chk_buffer(input logic [31:0] eres [8], input logic ez [8]);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      chk($sformatf("res[%0d]", i), rd_r, eres[i]);
      chk($sformatf("z[%0d]", i), {31'b0, rd_z}, {31'b0, ez[i]});
    end
  endtask

  initial begin
    run_rec_t rec;
    forever begin
      @(negedge clk or negedge rst_n);
      if (rst_req) begin
        rst_req = 0;
        #1;
        chk("rst_a", alu_a, 32'h0);
        chk("rst_b", alu_b, 32'h0);
        chk("rst_sel", {29'b0, alu_sel}, 32'h7);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_zcount", {28'b0, zcount}, 32'h0);
      end else begin
        if (timeout_req) begin
          timeout_req = 0;
          checks++;
          errors++;
          $display("FAIL run_timeout: done not seen within bound (cycle %0d)", cyc);
        end
        if (done === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 required no pulse (cycle %0d)", cyc);
          end else begin
            rec = exp_q.pop_front();
            chk("done_cycle", 32'(cyc), 32'(rec.done_cyc));
            chk("done_zcount", {28'b0, zcount}, 32'(rec.zc));
            chk("done_busy", {31'b0, busy}, 32'h1);
            chk_buffer(rec.res, rec.z);
          end
          runs_seen++;
        end else if (chk_req) begin
          chk("idle_a", alu_a, 32'h0);
          chk("idle_b", alu_b, 32'h0);
          chk("idle_sel", {29'b0, alu_sel}, 32'h7);
          chk("idle_busy", {31'b0, busy}, 32'h0);
          chk("idle_zcount", {28'b0, zcount}, 32'(m_zc));
          chk_buffer(m_res, m_z);
          chk_req = 0;
        end
        if (fin_req) begin
          $display("Simulation finished: %0d checks, %0d errors", checks, errors);
          $finish;
        end
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic make_rec(input int n, input int e0, output run_rec_t rec);
    int          nc;
    int          zc;
    logic [31:0] r;
    nc = (n > 8) ? 8 : n;
    zc = 0;
    for (int i = 0; i < nc; i++) begin
      r = alu_fn(m_a[i], m_b[i], m_sel[i]);
      m_res[i] = r;
      m_z[i]   = (r == 32'h0);
      if (r == 32'h0) zc++;
    end
    m_zc         = zc;
    rec.done_cyc = e0 + 2 * nc;
    rec.zc       = zc;
    rec.res      = m_res;
    rec.z        = m_z;
  endtask

  task automatic prog_write(input int addr, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] sel);
    prog_we = 1'b1;
    prog_addr = 3'(addr);
    prog_a = a;
    prog_b = b;
    prog_sel = sel;
    @(negedge clk);
    prog_we = 1'b0;
    m_a[addr] = a;
    m_b[addr] = b;
    m_sel[addr] = sel;
  endtask

  task automatic wait_runs(input int target);
    for (int t = 0; t < 200 && runs_seen < target; t++) @(negedge clk);
    if (runs_seen < target) begin
      timeout_req = 1;
      exp_q.delete();
      @(negedge clk);
    end
  endtask

  // mode 0: plain run, 1: start/prog_we poked mid-run, 2: start held for a second run
  task automatic do_run(input int n, input int mode);
    run_rec_t rec;
    int       e0;
    int       nc;
    int       target;
    nc = (n > 8) ? 8 : n;
    e0 = cyc + 1;
    make_rec(n, e0, rec);
    exp_q.push_back(rec);
    target = runs_seen + 1;
    num_ops = 4'(n);
    start = 1'b1;
    @(negedge clk);
    if (mode != 2) start = 1'b0;
    if (mode == 1) begin
      @(negedge clk);
      start = 1'b1;
      prog_we = 1'b1;
      prog_addr = 3'd0;
      prog_a = 32'hDEAD_BEEF;
      prog_b = 32'hFFFF_FFFF;
      prog_sel = 3'b001;
      @(negedge clk);
      start = 1'b0;
      prog_we = 1'b0;
    end
    if (mode == 2) begin
      make_rec(n, e0 + 2 * nc + 2, rec);
      exp_q.push_back(rec);
      target++;
      for (int t = 0; t < 60 && cyc < e0 + 2 * nc + 2; t++) @(negedge clk);
      start = 1'b0;
    end
    wait_runs(target);
  endtask

  task automatic idle_check();
    chk_req = 1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      m_res[i] = 32'h0;
      m_z[i] = 1'b0;
    end
    m_zc = 0;
  endtask

  function automatic logic [31:0] rand_b(input logic [31:0] a);
    case ($urandom_range(0, 4))
      0:       return ~a;
      1:       return a;
      2:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a;
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_check();

    // Two-op directed run
    prog_write(0, 32'h0C04_1820, 32'h2420_8100, 3'b000);
    prog_write(1, 32'h0C04_1820, 32'h2420_8100, 3'b001);
    do_run(2, 0);

    // Single op with zero result
    prog_write(0, 32'h0000_FFFF, 32'hFFFF_0000, 3'b000);
    do_run(1, 0);

    // Empty run
    do_run(0, 0);
    idle_check();

    // Full table, then clamp of an oversized count
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      prog_write(i, a, rand_b(a), 3'($urandom_range(0, 1)));
    end
    do_run(9, 0);
    do_run(8, 0);

    // Pokes while busy must not disturb the run or the table
    do_run(3, 1);
    do_run(3, 0);
    idle_check();

    // Start held across completion
    do_run(2, 2);
    do_run(0, 2);

    for (int it = 0; it < 20; it++) begin
      for (int w = 0; w < $urandom_range(0, 3); w++) begin
        a = $urandom;
        prog_write($urandom_range(0, 7), a, rand_b(a), 3'($urandom_range(0, 1)));
      end
      do_run($urandom_range(0, 15), ($urandom_range(0, 4) == 0) ? 2 : 0);
      if (it % 5 == 4) idle_check();
    end

    // Reset in the middle of a 4-op run
    for (int i = 0; i < 4; i++) prog_write(i, 32'hF0F0_1234, 32'hF0F0_1234, 3'b000);
    num_ops = 4'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_req = 1;
    rst_n = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_check();
    repeat (10) @(negedge clk);
    idle_check();

    fin_req = 1;
    repeat (4) @(negedge clk);
    $display("FAIL finish_handshake: got no summary required summary");
    $fatal(1);
  end

endmodule
`default_nettype wire
